// File: rtl/com_uart_tx_if.sv
// Byte strobe in from the CPU communication port, UART line and status out.
// Latency: none, wires only.
// Backpressure: none on the strobe; the producer watches fifo_full or accepts drops.
// Ports: byte_valid/byte_in carry bytes toward the transmitter; fifo_full, busy,
//        overflow and tx come back from it.
interface com_uart_tx_if;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       fifo_full;
  logic       busy;
  logic       overflow;
  logic       tx;

  modport master (
    output byte_valid, byte_in,
    input  fifo_full, busy, overflow, tx
  );

  modport slave (
    input  byte_valid, byte_in,
    output fifo_full, busy, overflow, tx
  );
endinterface

// File: rtl/com_uart_tx.sv
// Buffers CPU result bytes in a small FIFO and sends each one as an 8N1 UART frame on tx.
// Latency: byte in at edge E, start bit driven after E+1; one frame is 10*CLKS_PER_BIT cycles.
// Backpressure: none; a byte that arrives while the FIFO is full is dropped and overflow sticks.
// Ports: clk (CPU clock), reset (async, active low), cport (slave side of com_uart_tx_if):
//        byte_valid/byte_in in, fifo_full/busy/overflow/tx out.
module com_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic          clk,
  input  logic          reset,
  com_uart_tx_if.slave  cport
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic          full_q;
  logic          ovf_q;

  // transmitter
  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_q;

  logic bit_done;
  logic pop;
  logic push;
  logic drop;

  assign bit_done = (timer == TW'(CLKS_PER_BIT - 1));

  // The transmitter takes a byte whenever it is idle, or at the very end of a
  // stop bit so the next start bit follows with no gap.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (count != '0) begin
      pop = (state == IDLE) || ((state == STOP) && bit_done);
    end
    push = cport.byte_valid && ((count != (PW+1)'(FIFO_DEPTH)) || pop);
    drop = cport.byte_valid && !push;
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage is not reset: entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cport.byte_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_next;
      full_q <= (count_next == (PW+1)'(FIFO_DEPTH));
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Frame sequencer. tx is registered and set for the state being entered, so
  // the line changes on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          tx_q  <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            tx_q  <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_q    <= shift[0];
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 1'b1;
              tx_q    <= shift[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            timer <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              tx_q  <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign cport.tx        = tx_q;
  assign cport.fifo_full = full_q;
  assign cport.overflow  = ovf_q;
  assign cport.busy      = (state != IDLE) || (count != '0);

endmodule

// File: doc/com_uart_tx.md
# com_uart_tx

Downstream consumer of the processor's communication port. Accepts result bytes strobed out of the CPU top level (ReadDataOut qualified by a one-cycle valid) into a small FIFO, then serializes them as 8N1 UART frames on a single `tx` line toward the external host/interpreter. Runs in the CPU clock domain, so processor stalls never corrupt an in-flight frame.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2
- FIFO_DEPTH, 16, byte entries; power of two, ≥ 2
- clk  input  1  CPU clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- byte_valid  input  1  one-cycle strobe: byte_in is to be enqueued
- byte_in  input  8  result byte from the communication port
- fifo_full  output  1  FIFO holds FIFO_DEPTH bytes
- busy  output  1  high while the FIFO is non-empty or a frame is in flight
- overflow  output  1  sticky; a byte was dropped because the FIFO was full
- tx  output  1  UART serial line, idles high; registered output

## Operation
- FIFO: circular buffer with rd_ptr/wr_ptr of log2(FIFO_DEPTH) bits that wrap modulo depth, plus a count of log2(FIFO_DEPTH)+1 bits.
- Push when byte_valid and (count < FIFO_DEPTH or a pop happens in the same cycle).
- Push while full with no same-cycle pop: the byte is dropped, pointers are unchanged, and overflow is set. overflow clears only on reset.
- Pop: only the transmit FSM pops. A pop loads the head byte into a shift register.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: tx = 1. If count ≠ 0, pop and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Every CLKS_PER_BIT cycles, shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. At the end, if count ≠ 0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1. It resets on every state or bit transition.
- busy = (state ≠ IDLE) or (count ≠ 0). fifo_full = (count == FIFO_DEPTH).
- byte_valid is ignored while reset is low.

## Timing
- Reset values: tx = 1, busy = 0, fifo_full = 0, overflow = 0. FSM = IDLE, count = 0, both pointers = 0, shift register = 0.
- Reset asserted mid-frame: tx returns high asynchronously and buffered bytes are discarded. After release, no partial frame is resumed.
- Latency, FIFO empty and FSM idle:
  - byte_valid sampled at edge E → count = 1 after E.
  - Pop and START entry at edge E+1 → tx falls after E+1.
  - busy rises after E.
- One frame = 10 × CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit.
- fifo_full and overflow are registered and update on the same edge as the push/drop decision.
- busy falls on the edge that moves STOP → IDLE with count = 0.
- Sustained throughput is 1 byte per 10 × CLKS_PER_BIT cycles. The producer must respect fifo_full or accept drops.

## Test plan
- Single byte (CLKS_PER_BIT = 4): push 0xA5 → tx falls one edge after the push; line holds 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy deasserts after 40 cycles; overflow = 0.
- Burst of 3 bytes 0x01, 0x80, 0xFF on consecutive cycles → three contiguous frames with no idle gap; total 120 cycles of busy tx; decoded bytes match in order.
- Overflow (FIFO_DEPTH = 4, CLKS_PER_BIT = 4): push 6 bytes 0x10..0x15 on consecutive cycles → the first byte is popped on the second edge; 0x10..0x14 are transmitted; 0x15 is dropped; fifo_full pulses; overflow = 1 and stays 1.
- Push while full with a same-cycle pop at the STOP→START edge → the byte is accepted, count is unchanged, overflow stays 0.
- Pointer wrap: push 20 bytes 0x00..0x13, spaced to avoid overflow (FIFO_DEPTH = 16) → all 20 are received in order; pointers wrap correctly.
- Reset low mid-DATA of 0x3C with 2 bytes queued → tx = 1 immediately; busy = 0; count = 0; after release, tx stays high with no frame.
